// File: rtl/stream_sink_checker_pkg.sv
// Shared definitions for the stream sink checker: FSM encoding,
// backpressure LFSR shape, counter width and a constant clog2 helper.
package stream_sink_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Backpressure LFSR: x^8+x^6+x^5+x^4+1, Fibonacci, shifting towards the MSB.
  // Tap mask selects bits 7,5,4,3 whose XOR becomes the new LSB.
  localparam int         LFSR_W    = 8;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Word, frame and error counters all share this width.
  localparam int CNT_W = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_sink_checker_if.sv
// Valid/ready stream link between an upstream producer and the sink checker.
// The 'vaild' spelling is the established name of the valid strobe on this link.
interface stream_sink_checker_if #(
  parameter int WIDTH = 9
);

  logic             vaild;
  logic [WIDTH-1:0] data_in;
  logic             ready;

  modport master (
    output vaild,
    output data_in,
    input  ready
  );

  modport slave (
    input  vaild,
    input  data_in,
    output ready
  );

endinterface

// File: rtl/stream_sink_checker_bp_lfsr.sv
// Pseudo-random backpressure generator: an 8-bit LFSR that advances while
// enabled, and a threshold compare on the upcoming LFSR value that tells the
// sink whether to offer ready next cycle. Comparing the next value keeps the
// registered ready and the LFSR state in step with each other.
module bp_lfsr
  import stream_sink_checker_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED         = 8'hA5,
  parameter int                STALL_THRESH = 2
) (
  input  logic clk,
  input  logic s_rst_n,
  input  logic en,
  output logic ready_next
);

  localparam logic [3:0] THRESH_CMP = 4'(STALL_THRESH);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic              feedback;

  // Next LFSR value: shift in the tap parity when enabled, otherwise hold.
  always_comb begin
    feedback = ^(lfsr_q & LFSR_TAPS);
    lfsr_d   = lfsr_q;
    if (en) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], feedback};
    end
  end

  // LFSR state register, reloads the non-zero seed on reset.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign ready_next = ({1'b0, lfsr_d[2:0]} >= THRESH_CMP);

endmodule

// File: rtl/stream_sink_checker.sv
// Stream sink checker: consumes a valid/ready stream under pseudo-random
// backpressure, checks each frame against the incrementing pattern
// 0..DEPTH-1 with resync after a mismatch, and watches that the upstream
// keeps valid and data stable while it is being stalled.
module stream_sink_checker
  import stream_sink_checker_pkg::*;
#(
  parameter int                WIDTH        = 9,
  parameter int                DEPTH        = 256,
  parameter int                STALL_THRESH = 2,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 8'hA5
) (
  input  logic                 clk,
  input  logic                 s_rst_n,
  input  logic                 start,
  stream_sink_checker_if.slave link,
  output logic                 done,
  output logic [CNT_W-1:0]     rx_cnt,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 proto_err,
  output logic [WIDTH-1:0]     first_err_data
);

  localparam int               EXP_W     = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam logic [EXP_W-1:0] LAST_IDX  = EXP_W'(DEPTH - 1);
  localparam logic [WIDTH-1:0] LAST_DATA = WIDTH'(DEPTH - 1);

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [EXP_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] rx_q, rx_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             proto_q, proto_d;
  logic             stall_q, stall_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic             seen_err_q, seen_err_d;
  logic [WIDTH-1:0] first_q, first_d;

  logic             ready_next;
  logic             xfer;
  logic             last_word;
  logic             mismatch;
  logic [EXP_W-1:0] resync_exp;

  bp_lfsr #(
    .SEED         (LFSR_SEED),
    .STALL_THRESH (STALL_THRESH)
  ) u_bp_lfsr (
    .clk        (clk),
    .s_rst_n    (s_rst_n),
    .en         (state_q == RECV),
    .ready_next (ready_next)
  );

  assign xfer      = (state_q == RECV) && link.vaild && ready_q;
  assign last_word = (wcnt_q == LAST_IDX);
  assign mismatch  = (link.data_in != WIDTH'(exp_q));

  // After any accepted word the checker expects the word that follows it,
  // so a match simply increments and a mismatch resyncs onto the stream.
  assign resync_exp = (link.data_in >= LAST_DATA) ? '0
                                                  : EXP_W'(link.data_in + WIDTH'(1));

  // FSM state register.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the registered ready/done decisions for the coming cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RECV;
      RECV:    if (xfer && last_word) state_d = DONE;
      DONE:    state_d = start ? RECV : IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == RECV) ? ready_next : 1'b0;
    done_d  = (state_d == DONE);
  end

  // Datapath next state: counters, expected-word tracking, error capture
  // and the stall stability watch.
  always_comb begin
    exp_d      = exp_q;
    wcnt_d     = wcnt_q;
    rx_d       = rx_q;
    frame_d    = frame_q;
    err_d      = err_q;
    proto_d    = proto_q;
    seen_err_d = seen_err_q;
    first_d    = first_q;
    stall_d    = (state_q == RECV) && link.vaild && !ready_q;
    cap_d      = stall_d ? link.data_in : cap_q;

    if (xfer) begin
      rx_d   = rx_q + CNT_W'(1);
      wcnt_d = last_word ? '0 : wcnt_q + EXP_W'(1);
      exp_d  = resync_exp;
      if (mismatch) begin
        if (err_q != '1) begin
          err_d = err_q + CNT_W'(1);
        end
        if (!seen_err_q) begin
          seen_err_d = 1'b1;
          first_d    = link.data_in;
        end
      end
    end

    if (state_q == DONE) begin
      frame_d = frame_q + CNT_W'(1);
      exp_d   = '0;
      wcnt_d  = '0;
    end

    if (stall_q && (!link.vaild || (link.data_in != cap_q))) begin
      proto_d = 1'b1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      exp_q      <= '0;
      wcnt_q     <= '0;
      rx_q       <= '0;
      frame_q    <= '0;
      err_q      <= '0;
      proto_q    <= 1'b0;
      stall_q    <= 1'b0;
      cap_q      <= '0;
      seen_err_q <= 1'b0;
      first_q    <= '0;
    end else begin
      ready_q    <= ready_d;
      done_q     <= done_d;
      exp_q      <= exp_d;
      wcnt_q     <= wcnt_d;
      rx_q       <= rx_d;
      frame_q    <= frame_d;
      err_q      <= err_d;
      proto_q    <= proto_d;
      stall_q    <= stall_d;
      cap_q      <= cap_d;
      seen_err_q <= seen_err_d;
      first_q    <= first_d;
    end
  end

  assign link.ready     = ready_q;
  assign done           = done_q;
  assign rx_cnt         = rx_q;
  assign frame_cnt      = frame_q;
  assign err_cnt        = err_q;
  assign proto_err      = proto_q;
  assign first_err_data = first_q;

endmodule

// File: tb/tb_stream_sink_checker.sv
// Bench for stream_sink_checker: one instance without backpressure and one
// with STALL_THRESH=4, fed by a randomized source and checked against a
// word-level reference model of the sequence and backpressure rules.
module tb_stream_sink_checker;
  import stream_sink_checker_pkg::*;

  localparam int         WIDTH = 9;
  localparam int         DEPTH = 256;
  localparam int         TH_A  = 0;
  localparam int         TH_B  = 4;
  localparam logic [7:0] SEED  = 8'hA5;

  logic             clk = 1'b0;
  logic             rstN;
  logic             start   [2];
  logic             vaild   [2];
  logic [WIDTH-1:0] dataIn  [2];
  logic             readyW  [2];
  logic             doneW   [2];
  logic [15:0]      rxW     [2];
  logic [15:0]      frameW  [2];
  logic [15:0]      errW    [2];
  logic             protoW  [2];
  logic [WIDTH-1:0] firstW  [2];

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] words [$];

  int         mRx      [2];
  int         mErr     [2];
  int         mExp     [2];
  int         mFirst   [2];
  int         mInFrame [2];
  bit         mSeen    [2];
  logic [7:0] mLfsr    [2];
  int         doneCnt  [2];

  always #5 clk = ~clk;

  stream_sink_checker_if #(.WIDTH(WIDTH)) linkA ();
  stream_sink_checker_if #(.WIDTH(WIDTH)) linkB ();

  assign linkA.vaild   = vaild[0];
  assign linkA.data_in = dataIn[0];
  assign readyW[0]     = linkA.ready;
  assign linkB.vaild   = vaild[1];
  assign linkB.data_in = dataIn[1];
  assign readyW[1]     = linkB.ready;

  stream_sink_checker #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_THRESH(TH_A), .LFSR_SEED(SEED)
  ) dutA (
    .clk(clk), .s_rst_n(rstN), .start(start[0]), .link(linkA),
    .done(doneW[0]), .rx_cnt(rxW[0]), .frame_cnt(frameW[0]), .err_cnt(errW[0]),
    .proto_err(protoW[0]), .first_err_data(firstW[0])
  );

  stream_sink_checker #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_THRESH(TH_B), .LFSR_SEED(SEED)
  ) dutB (
    .clk(clk), .s_rst_n(rstN), .start(start[1]), .link(linkB),
    .done(doneW[1]), .rx_cnt(rxW[1]), .frame_cnt(frameW[1]), .err_cnt(errW[1]),
    .proto_err(protoW[1]), .first_err_data(firstW[1])
  );

  // Count done pulses per instance since the last reset.
  always @(negedge clk or negedge rstN) begin
    if (!rstN) begin
      doneCnt[0] <= 0;
      doneCnt[1] <= 0;
    end else begin
      doneCnt[0] <= doneCnt[0] + int'(doneW[0]);
      doneCnt[1] <= doneCnt[1] + int'(doneW[1]);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Backpressure polynomial x^8+x^6+x^5+x^4+1 in Fibonacci form.
  function automatic logic [7:0] nextLfsr(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic void clearModel();
    for (int i = 0; i < 2; i++) begin
      mRx[i]      = 0;
      mErr[i]     = 0;
      mExp[i]     = 0;
      mFirst[i]   = 0;
      mInFrame[i] = 0;
      mSeen[i]    = 1'b0;
      mLfsr[i]    = SEED;
      start[i]    = 1'b0;
      vaild[i]    = 1'b0;
      dataIn[i]   = '0;
    end
    words.delete();
  endfunction

  // Word-level model of one accepted word.
  function automatic void modelAccept(input int sel, input int w);
    mRx[sel]++;
    if (w != mExp[sel]) begin
      if (mErr[sel] < 65535) mErr[sel]++;
      if (!mSeen[sel]) begin
        mSeen[sel]  = 1'b1;
        mFirst[sel] = w;
      end
    end
    mExp[sel] = (w >= DEPTH - 1) ? 0 : w + 1;
    mInFrame[sel]++;
    if (mInFrame[sel] == DEPTH) begin
      mInFrame[sel] = 0;
      mExp[sel]     = 0;
    end
  endfunction

  function automatic void buildFrame(input int skipIdx, input int replIdx,
                                     input int replVal, input int extra);
    words.delete();
    for (int i = 0; i < DEPTH; i++) begin
      if (i != skipIdx) words.push_back((i == replIdx) ? WIDTH'(replVal) : WIDTH'(i));
    end
    if (extra >= 0) words.push_back(WIDTH'(extra));
  endfunction

  // Randomized source for the RECV cycles: starts at the first RECV cycle,
  // returns right after the edge that carries the last requested transfer.
  task automatic applyStimulus(input int sel, input int maxXfer, output int cycles);
    bit               holding;
    int               n;
    logic             rdy;
    logic             expRdy;
    logic [WIDTH-1:0] w;
    holding = 1'b0;
    n       = 0;
    cycles  = 0;
    while (n < maxXfer && words.size() > 0 && cycles < 4000) begin
      @(negedge clk);
      cycles++;
      expRdy = (int'(mLfsr[sel][2:0]) >= ((sel == 0) ? TH_A : TH_B));
      checkOutput("readyPattern", 32'(readyW[sel]), 32'(expRdy));
      mLfsr[sel] = nextLfsr(mLfsr[sel]);
      if (!holding) begin
        vaild[sel]  = ($urandom_range(3, 0) != 0);
        dataIn[sel] = vaild[sel] ? words[0] : WIDTH'($urandom);
      end
      rdy = readyW[sel];
      @(posedge clk);
      if (vaild[sel] && rdy) begin
        w = words.pop_front();
        modelAccept(sel, int'(w));
        n++;
        holding = 1'b0;
      end else begin
        holding = vaild[sel];
      end
    end
    checkOutput("xferBudget", n, maxXfer);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 rstN = 1'b0;
    clearModel();
    @(negedge clk);
    #2 rstN = 1'b1;
  endtask

  task automatic checkDoneCycle(input int sel, input string tag);
    @(negedge clk);
    vaild[sel] = 1'b0;
    checkOutput({tag, "_done"}, 32'(doneW[sel]), 1);
    checkOutput({tag, "_readyLow"}, 32'(readyW[sel]), 0);
  endtask

  initial begin
    int  cyc;
    bit  found;

    rstN = 1'b0;
    clearModel();
    #1;
    checkOutput("rstReady", 32'(readyW[0]), 0);
    checkOutput("rstDone", 32'(doneW[0]), 0);
    checkOutput("rstRx", 32'(rxW[0]), 0);
    checkOutput("rstFrame", 32'(frameW[0]), 0);
    checkOutput("rstErr", 32'(errW[0]), 0);
    checkOutput("rstProto", 32'(protoW[0]), 0);
    checkOutput("rstFirst", 32'(firstW[0]), 0);
    #11 rstN = 1'b1;

    // Instance A: two back-to-back frames with start held, then a third
    // frame with start dropped mid-way.
    @(negedge clk);
    start[0] = 1'b1;
    buildFrame(-1, -1, 0, -1);
    applyStimulus(0, DEPTH, cyc);
    checkDoneCycle(0, "aFrame1");
    checkOutput("aRx1", 32'(rxW[0]), 256);
    buildFrame(-1, -1, 0, -1);
    applyStimulus(0, DEPTH, cyc);
    checkDoneCycle(0, "aFrame2");
    buildFrame(-1, -1, 0, -1);
    applyStimulus(0, 100, cyc);
    start[0] = 1'b0;
    applyStimulus(0, DEPTH - 100, cyc);
    checkDoneCycle(0, "aFrame3");
    @(negedge clk);
    checkOutput("aIdleReady", 32'(readyW[0]), 0);
    checkOutput("aIdleDone", 32'(doneW[0]), 0);
    vaild[0]  = 1'b1;
    dataIn[0] = '0;
    repeat (4) @(negedge clk);
    vaild[0] = 1'b0;
    checkOutput("aIdleNoXfer", 32'(rxW[0]), mRx[0]);
    checkOutput("aIdleNoProto", 32'(protoW[0]), 0);
    checkOutput("aFrames", 32'(frameW[0]), mRx[0] / DEPTH);
    checkOutput("aErr", 32'(errW[0]), mErr[0]);
    checkOutput("aDonePulses", doneCnt[0], 3);

    // Instance B: backpressured frames, one replaced word, then one dropped
    // word plus a mismatching frame-final word.
    @(negedge clk);
    start[1] = 1'b1;
    buildFrame(-1, 17, 99, -1);
    applyStimulus(1, DEPTH, cyc);
    checkOutput("bStallCycles", 32'(cyc > DEPTH), 1);
    checkDoneCycle(1, "bFrame1");
    checkOutput("bErr1", 32'(errW[1]), mErr[1]);
    checkOutput("bFirst1", 32'(firstW[1]), 99);
    checkOutput("bRx1", 32'(rxW[1]), mRx[1]);
    buildFrame(40, -1, 0, 7);
    applyStimulus(1, DEPTH, cyc);
    checkDoneCycle(1, "bFrame2");
    start[1] = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("bErr2", 32'(errW[1]), mErr[1]);
    checkOutput("bFirst2", 32'(firstW[1]), mFirst[1]);
    checkOutput("bFrames", 32'(frameW[1]), mRx[1] / DEPTH);
    checkOutput("bRx2", 32'(rxW[1]), mRx[1]);
    checkOutput("bDonePulses", doneCnt[1], 2);
    checkOutput("bNoProto", 32'(protoW[1]), 0);

    // Stability: data changes 5 -> 6 while stalled, then vaild drops while stalled.
    for (int variant = 0; variant < 2; variant++) begin
      doReset();
      checkOutput("protoAfterReset", 32'(protoW[1]), 0);
      @(negedge clk);
      start[1] = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 64 && !found; k++) begin
        @(negedge clk);
        if (!readyW[1]) begin
          vaild[1]  = 1'b1;
          dataIn[1] = 9'd5;
          found     = 1'b1;
        end
      end
      checkOutput("stallFound", 32'(found), 1);
      @(negedge clk);
      checkOutput("protoBefore", 32'(protoW[1]), 0);
      if (variant == 0) dataIn[1] = 9'd6;
      else              vaild[1]  = 1'b0;
      @(negedge clk);
      checkOutput("protoSet", 32'(protoW[1]), 1);
      vaild[1] = 1'b0;
      start[1] = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("protoSticky", 32'(protoW[1]), 1);
    end

    // Asynchronous reset after word 100, then a clean frame from scratch.
    doReset();
    @(negedge clk);
    start[1] = 1'b1;
    buildFrame(-1, -1, 0, -1);
    applyStimulus(1, 100, cyc);
    #1;
    checkOutput("rxBeforeReset", 32'(rxW[1]), 100);
    #1 rstN = 1'b0;
    #1;
    checkOutput("asyncReady", 32'(readyW[1]), 0);
    checkOutput("asyncRx", 32'(rxW[1]), 0);
    checkOutput("asyncErr", 32'(errW[1]), 0);
    checkOutput("asyncFrame", 32'(frameW[1]), 0);
    checkOutput("asyncProto", 32'(protoW[1]), 0);
    checkOutput("asyncDone", 32'(doneW[1]), 0);
    clearModel();
    @(negedge clk);
    #2 rstN = 1'b1;
    @(negedge clk);
    start[1] = 1'b1;
    buildFrame(-1, -1, 0, -1);
    applyStimulus(1, DEPTH, cyc);
    checkDoneCycle(1, "bAfterReset");
    start[1] = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("postRstErr", 32'(errW[1]), 0);
    checkOutput("postRstRx", 32'(rxW[1]), mRx[1]);
    checkOutput("postRstFrames", 32'(frameW[1]), 1);
    checkOutput("postRstFirst", 32'(firstW[1]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
